// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte FIFO between the UART RX FSM and the APB read path.
// Stores received bytes, flags dropped bytes, counts frame errors and raises
// a level interrupt at or above a threshold occupancy.
//
// Parameters
//   DEPTH     number of entries, power of two in 2..64
//   THRESH    occupancy at or above which irq_level asserts, 1..DEPTH
// Ports
//   clk       clock, rising edge
//   arst      asynchronous active-high reset
//   rst       synchronous active-high soft clear (wins over everything else)
//   wr_data   received byte
//   wr_valid  single-cycle push strobe
//   rx_error  single-cycle frame-error strobe
//   rd_en     pop request
//   clr_ovf   clears the overflow flag
//   clr_err   clears err_cnt
//   rd_data   head entry, first-word-fall-through, 8'h00 when empty
//   empty     level == 0
//   full      level == DEPTH
//   level     current occupancy
//   overflow  sticky dropped-byte flag
//   err_cnt   saturating frame-error count
//   irq_level registered (level >= THRESH)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned THRESH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  input  logic                     rx_error,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               err_cnt,
  output logic                     irq_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             irq_q, irq_d;

  logic             empty_c, full_c;
  logic             pop_c, push_c, drop_c;

  // Status derived from the registered occupancy
  assign empty_c = (level_q == '0);
  assign full_c  = (level_q == LVL_W'(DEPTH));

  // A pop frees the slot the push needs, so a full FIFO still accepts a
  // byte when it is read on the same edge; an empty FIFO ignores the pop.
  assign pop_c  = rd_en && !empty_c;
  assign push_c = wr_valid && (!full_c || pop_c);
  assign drop_c = wr_valid && full_c && !pop_c;

  // Next-state logic; soft clear overrides every other update
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A coincident drop beats the clear so no lost byte goes unreported
    if (drop_c)       overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;

    if (clr_err)                            err_cnt_d = 8'h00;
    else if (rx_error && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    if (rst) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      err_cnt_d  = 8'h00;
    end

    irq_d = (level_d >= LVL_W'(THRESH));
  end

  // Control state registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
      irq_q      <= irq_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push_c && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = empty_c ? 8'h00 : mem_q[rd_ptr_q];
  assign empty     = empty_c;
  assign full      = full_c;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign err_cnt   = err_cnt_q;
  assign irq_level = irq_q;

endmodule
